// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular-buffer FIFO.
// Queued bytes go out back to back: a new start bit follows a stop bit
// directly, with no idle gap, whenever the FIFO still holds data.
module uart_tx_fifo #(
    parameter int DIV_RATE   = 260,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_end,
    output logic [PTR_W:0]   fifo_count,
    output logic             tx
);

    localparam int               DIV_W    = $clog2(DIV_RATE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATE - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // Serializer state
    state_e           state_q,   state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic             tx_end_q,  tx_end_d;
    logic             bit_done;

    assign tx_ready = (count_q != FULL_CNT);
    assign push     = tx_valid && tx_ready;
    assign head     = mem_q[rd_ptr_q];
    assign bit_done = (div_cnt_q == DIV_LAST);

    // Byte storage: written on every accepted push
    // NOTE: the data array carries no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serializer next-state: bit timing, frame sequencing and FIFO pops
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        tx_end_d  = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                tx_d      = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    div_cnt_d = '0;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    div_cnt_d = '0;
                    tx_end_d  = 1'b1;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serializer registers; reset abandons any frame in flight and idles the line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            tx_end_q  <= tx_end_d;
        end
    end

    assign tx         = tx_q;
    assign tx_end     = tx_end_q;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);

endmodule
